uram_wide_loader_arb: RTL and testbench
=======================================

// Module: uram_wide_loader_arb
// PURPOSE
//  Sequencer and arbiter in front of one uram_wide instance. Converts a host
//  DIN_LEN-bit valid/ready stream into a full-image load, holding the URAM
//  write-enable for the whole session plus the pipeline drain. Then it shares
//  the read port between two requesters, round-robin, and tags each response.
// PARAMETERS
//  ADDR_LEN     9    URAM row address width; DEPTH = 2**ADDR_LEN rows
//  DATA_LEN     128  URAM row width (bits)
//  DIN_LEN      8    load beat width; DATA_LEN % DIN_LEN == 0
//  DRAIN_CYCLES 3    cycles uram_we stays high after the last beat is issued
//  RD_LATENCY   2    cycles from read grant to valid uram_dout
// PORTS
//  clk           in   1            clock
//  rst_n         in   1            asynchronous reset, active low
//  load_start    in   1            pulse: begin load of load_rows rows
//  load_rows     in   ADDR_LEN+1   rows to load; values > DEPTH clamp to DEPTH
//  s_data        in   DIN_LEN      load beat; row LSB beat first
//  s_valid       in   1            beat valid
//  s_ready       out  1            beat accepted when s_valid & s_ready
//  load_busy     out  1            high in LOAD or DRAIN
//  load_done     out  1            1-cycle pulse when the image is committed
//  rdN_req       in   1            N=0,1: read request, held until granted
//  rdN_addr      in   ADDR_LEN     N=0,1: read row address
//  rdN_gnt       out  1            N=0,1: combinational grant; request consumed
//  rsp_valid     out  1            response data valid
//  rsp_id        out  1            requester index of the response
//  rsp_data      out  DATA_LEN     = uram_dout
//  uram_we       out  1            to uram_wide.we
//  uram_din      out  DIN_LEN      to uram_wide.din
//  uram_din_valid out 1            to uram_wide.din_valid
//  uram_addr     out  ADDR_LEN     to uram_wide.addr
//  uram_dout     in   DATA_LEN     from uram_wide.dout
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except rsp_data (follows uram_dout);
//   counters cleared. Reset takes effect in any state, mid-load included.
//   uram_we drops, so uram_wide discards its partial row and address.
//  FSM states: IDLE, LOAD, DRAIN, READY.
//  IDLE/READY + load_start: latch min(load_rows,DEPTH) -> LOAD, uram_we=1 next
//   cycle. If the latched count is 0: no uram_we; pulse load_done; -> READY.
//   load_start in LOAD/DRAIN is ignored.
//  LOAD: s_ready=1. Each accepted beat drives uram_din=s_data and
//   uram_din_valid=1 in the next cycle (registered); otherwise din_valid=0.
//   beat_cnt counts 0..XFERS-1 (XFERS=DATA_LEN/DIN_LEN). row_cnt increments
//   on each wrap. On the final beat of the final row: s_ready=0 from the next
//   cycle, -> DRAIN.
//  DRAIN: uram_we=1 and din_valid=0 for DRAIN_CYCLES cycles. Then uram_we=0,
//   load_done pulses 1 cycle, -> READY. uram_we never drops mid-image.
//  Reads: arbitration only in READY; gnts=0 in IDLE/LOAD/DRAIN.
//   With one requester, grant it. With both, grant the one not granted last.
//   Priority resets to rd0 on reset.
//   uram_addr = granted rdN_addr in the grant cycle, else 0 (held while
//   uram_we=1; uram_wide ignores it then).
//   rsp_valid/rsp_id = the grant delayed by a RD_LATENCY-deep shift register.
//   The shift register keeps running in all states, so in-flight reads
//   complete even if a load starts.
//  Widths: beat_cnt is $clog2(XFERS) bits (min 1); row_cnt is ADDR_LEN+1 bits.
// TESTING
//  1 reset: assert rst_n=0 mid-LOAD (row 1, beat 3) -> next edge: uram_we=0,
//    s_ready=0, load_busy=0, gnts=0; a later load restarts at row 0.
//  2 load DATA_LEN=16,DIN_LEN=8, load_rows=2, beats A1,A2,B1,B2 with a 2-cycle
//    s_valid gap -> exactly 4 din_valid pulses, uram_we high continuously to
//    DRAIN end (+3), one load_done pulse; readback row0=A2A1, row1=B2B1.
//  3 load_rows=0 -> load_done one cycle after start, uram_we never asserted.
//  4 load_rows=DEPTH+5 -> DEPTH*XFERS beats accepted, then s_ready=0.
//  5 READY, both req held 4 cycles -> gnt sequence 0,1,0,1; rsp_id 0,1,0,1
//    exactly RD_LATENCY cycles after each grant, with matching data.
//  6 rd0_req during LOAD/DRAIN -> no gnt; granted first cycle of READY.

Source files
------------

// File: rtl/uram_wide_loader_arb.sv
// Load sequencer and two-port round-robin read arbiter for uram_wide.
// Streams a full image into the URAM, then shares its read port.
module uram_wide_loader_arb #(
  parameter int ADDR_LEN     = 9,
  parameter int DATA_LEN     = 128,
  parameter int DIN_LEN      = 8,
  parameter int DRAIN_CYCLES = 3,
  parameter int RD_LATENCY   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_start,
  input  logic [ADDR_LEN:0]   load_rows,
  input  logic [DIN_LEN-1:0]  s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                load_busy,
  output logic                load_done,
  input  logic                rd0_req,
  input  logic [ADDR_LEN-1:0] rd0_addr,
  output logic                rd0_gnt,
  input  logic                rd1_req,
  input  logic [ADDR_LEN-1:0] rd1_addr,
  output logic                rd1_gnt,
  output logic                rsp_valid,
  output logic                rsp_id,
  output logic [DATA_LEN-1:0] rsp_data,
  output logic                uram_we,
  output logic [DIN_LEN-1:0]  uram_din,
  output logic                uram_din_valid,
  output logic [ADDR_LEN-1:0] uram_addr,
  input  logic [DATA_LEN-1:0] uram_dout
);

  localparam int XFERS = DATA_LEN / DIN_LEN;
  localparam int BW = (XFERS > 1) ? $clog2(XFERS) : 1;
  localparam int DW = (DRAIN_CYCLES > 0) ?
                      $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [BW-1:0] BEAT_MAX = BW'(XFERS - 1);
  localparam logic [DW-1:0] DRAIN_MAX = DW'(DRAIN_CYCLES);
  localparam logic [ADDR_LEN:0] DEPTH =
    {1'b1, {ADDR_LEN{1'b0}}};

  typedef enum logic [1:0] {
    IDLE, LOAD, DRAIN, READY
  } state_t;

  state_t state, state_nx;

  logic [ADDR_LEN:0]     rows_q;
  logic [ADDR_LEN:0]     row_cnt;
  logic [ADDR_LEN:0]     rows_clamp;
  logic [BW-1:0]         beat_cnt;
  logic [DW-1:0]         drain_cnt;
  logic                  accept;
  logic                  last_beat;
  logic                  start;
  logic                  ready_st;
  logic                  last_gnt;
  logic [RD_LATENCY-1:0] sr_v;
  logic [RD_LATENCY-1:0] sr_id;

  assign rows_clamp = (load_rows > DEPTH) ? DEPTH : load_rows;
  assign ready_st   = (state == READY);
  assign start      = load_start &&
                      (state == IDLE || state == READY);
  assign s_ready    = (state == LOAD);
  assign uram_we    = (state == LOAD) || (state == DRAIN);
  assign load_busy  = uram_we;
  assign accept     = s_valid && s_ready;
  assign last_beat  = accept && (beat_cnt == BEAT_MAX) &&
                      (row_cnt == rows_q - 1'b1);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, READY: begin
        if (load_start)
          state_nx = (rows_clamp == '0) ? READY : LOAD;
      end
      LOAD: begin
        if (last_beat) state_nx = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_MAX) state_nx = READY;
      end
      default: state_nx = IDLE;
    endcase
  end

  // last_gnt=1 after reset so rd0 wins the first contested cycle
  assign rd0_gnt = ready_st && rd0_req &&
                   (!rd1_req || last_gnt);
  assign rd1_gnt = ready_st && rd1_req &&
                   (!rd0_req || !last_gnt);

  always_comb begin
    uram_addr = '0;
    unique case (1'b1)
      rd0_gnt: uram_addr = rd0_addr;
      rd1_gnt: uram_addr = rd1_addr;
      default: uram_addr = '0;
    endcase
  end

  assign rsp_valid = sr_v[RD_LATENCY-1];
  assign rsp_id    = sr_id[RD_LATENCY-1];
  assign rsp_data  = uram_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rows_q         <= '0;
      row_cnt        <= '0;
      beat_cnt       <= '0;
      drain_cnt      <= '0;
      load_done      <= 1'b0;
      uram_din       <= '0;
      uram_din_valid <= 1'b0;
      last_gnt       <= 1'b1;
      sr_v           <= '0;
      sr_id          <= '0;
    end else begin
      state          <= state_nx;
      uram_din_valid <= accept;
      if (accept) uram_din <= s_data;
      load_done <= (start && rows_clamp == '0) ||
                   (state == DRAIN &&
                    drain_cnt == DRAIN_MAX);
      if (start) begin
        rows_q    <= rows_clamp;
        row_cnt   <= '0;
        beat_cnt  <= '0;
        drain_cnt <= '0;
      end
      if (accept) begin
        if (beat_cnt == BEAT_MAX) begin
          beat_cnt <= '0;
          row_cnt  <= row_cnt + 1'b1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
      if (state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
      if (rd0_gnt || rd1_gnt) last_gnt <= rd1_gnt;
      sr_v[0]  <= rd0_gnt || rd1_gnt;
      sr_id[0] <= rd1_gnt;
      for (int i = 1; i < RD_LATENCY; i++) begin
        sr_v[i]  <= sr_v[i-1];
        sr_id[i] <= sr_id[i-1];
      end
    end
  end

endmodule

// File: tb/tb_uram_wide_loader_arb.sv
// Bench for uram_wide_loader_arb with a behavioural uram_wide
// and a spec-level model of loading and round-robin reads.
module tb_uram_wide_loader_arb;

  localparam int A     = 3;
  localparam int DEPTH = 1 << A;
  localparam int D     = 16;
  localparam int DI    = 8;
  localparam int XF    = D / DI;
  localparam int DRN   = 3;
  localparam int LAT   = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic [A:0]    load_rows = '0;
  logic [DI-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready, load_busy, load_done;
  logic          rd0_req = 1'b0, rd1_req = 1'b0;
  logic [A-1:0]  rd0_addr = '0, rd1_addr = '0;
  logic          rd0_gnt, rd1_gnt;
  logic          rsp_valid, rsp_id;
  logic [D-1:0]  rsp_data;
  logic          uram_we, uram_din_valid;
  logic [DI-1:0] uram_din;
  logic [A-1:0]  uram_addr;
  logic [D-1:0]  uram_dout;

  uram_wide_loader_arb #(
    .ADDR_LEN(A), .DATA_LEN(D), .DIN_LEN(DI),
    .DRAIN_CYCLES(DRN), .RD_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_rows(load_rows),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .load_busy(load_busy), .load_done(load_done),
    .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_gnt(rd0_gnt),
    .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_gnt(rd1_gnt),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data),
    .uram_we(uram_we), .uram_din(uram_din),
    .uram_din_valid(uram_din_valid),
    .uram_addr(uram_addr), .uram_dout(uram_dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural uram_wide: assemble beats LSB-first into rows
  logic [D-1:0] mem [DEPTH];
  logic [D-1:0] acc, p0, p1;
  int           wbc = 0;
  logic [A-1:0] wa = '0;
  always @(posedge clk) begin
    if (!uram_we) begin
      wbc <= 0;
      wa  <= '0;
    end else if (uram_din_valid) begin
      acc <= {uram_din, acc[D-1:DI]};
      if (wbc == XF - 1) begin
        mem[wa] <= {uram_din, acc[D-1:DI]};
        wa  <= wa + 1'b1;
        wbc <= 0;
      end else begin
        wbc <= wbc + 1;
      end
    end
    p0 <= mem[uram_addr];
    p1 <= p0;
  end
  assign uram_dout = p1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input logic [D-1:0] act,
                     input logic [D-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  logic [D-1:0] img [DEPTH];
  bit           mlast = 1'b1;
  bit           mon_en = 1'b0;

  typedef struct {
    int           due;
    bit           id;
    logic [D-1:0] d;
  } rsp_t;
  rsp_t rq[$];

  always @(negedge clk) begin
    if (mon_en) begin
      if (rq.size() > 0 && rq[0].due == cyc) begin
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_id", rsp_id, rq[0].id);
        chk("rsp_data", rsp_data, rq[0].d);
        void'(rq.pop_front());
      end else begin
        chk("rsp_idle", rsp_valid, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rsp(input bit id, input logic [A-1:0] a);
    rsp_t r;
    r.due = cyc + LAT;
    r.id  = id;
    r.d   = img[a];
    rq.push_back(r);
  endtask

  task automatic pred(input bit r0, input bit r1,
                      output bit e0, output bit e1);
    if (r0 && r1) begin
      e0 = mlast;
      e1 = !mlast;
    end else begin
      e0 = r0;
      e1 = r1;
    end
  endtask

  task automatic rd_cyc(input bit r0, input logic [A-1:0] a0,
                        input bit r1, input logic [A-1:0] a1,
                        input bit e0, input bit e1);
    logic [A-1:0] ea;
    rd0_req = r0; rd0_addr = a0;
    rd1_req = r1; rd1_addr = a1;
    ea = e0 ? a0 : (e1 ? a1 : '0);
    @(negedge clk);
    chk("rd0_gnt", rd0_gnt, e0);
    chk("rd1_gnt", rd1_gnt, e1);
    chk("uram_addr", uram_addr, ea);
    if (e0 || e1) begin
      push_rsp(e1, ea);
      mlast = e1;
    end
    tick();
  endtask

  task automatic rand_reads(input int n, input int nr);
    bit p0 = 0, p1 = 0, e0, e1;
    logic [A-1:0] a0 = '0, a1 = '0;
    for (int i = 0; i < n; i++) begin
      if (!p0 && $urandom_range(0, 1) == 1) begin
        p0 = 1; a0 = A'($urandom_range(0, nr - 1));
      end
      if (!p1 && $urandom_range(0, 1) == 1) begin
        p1 = 1; a1 = A'($urandom_range(0, nr - 1));
      end
      pred(p0, p1, e0, e1);
      rd_cyc(p0, a0, p1, a1, e0, e1);
      if (e0) p0 = 0;
      if (e1) p1 = 0;
    end
    rd0_req = 0;
    rd1_req = 0;
  endtask

  // mode 0: valid every cycle except a 2-cycle gap after beat 2
  task automatic do_load(input int n, input int mode,
                         input bit hold0,
                         input logic [A-1:0] h_addr);
    int exp_beats, acc_n, dv, lastdv, t, t_done, gap;
    bit gapped, we_bad, rdy_bad, gnt_bad, din_bad, got;
    logic [DI-1:0] bq[$];
    exp_beats = ((n > DEPTH) ? DEPTH : n) * XF;
    acc_n = 0; dv = 0; lastdv = -1; t = 1; t_done = -1;
    gap = 0; gapped = 0; we_bad = 0; rdy_bad = 0;
    gnt_bad = 0; din_bad = 0;
    load_start = 1; load_rows = (A+1)'(n);
    tick();
    load_start = 0;
    rd0_req = hold0; rd0_addr = h_addr;
    while (t < 400 && t_done < 0) begin
      s_valid = (mode == 0) ? (gap == 0)
                            : ($urandom_range(0, 3) != 0);
      s_data = DI'($urandom);
      @(negedge clk);
      if (load_done) begin
        t_done = t;
        if (hold0) begin
          chk("held_rd0_gnt", rd0_gnt, 1);
          chk("held_rd0_addr", uram_addr, h_addr);
          push_rsp(0, h_addr);
          mlast = 0;
        end
      end else begin
        if (uram_we !== 1'b1) we_bad = 1;
        if (rd0_gnt || rd1_gnt) gnt_bad = 1;
      end
      if (uram_din_valid) begin
        dv++;
        lastdv = t;
        if (bq.size() == 0 || uram_din !== bq[0]) din_bad = 1;
        if (bq.size() > 0) void'(bq.pop_front());
      end
      if (s_ready && acc_n >= exp_beats) rdy_bad = 1;
      got = s_valid && s_ready && acc_n < exp_beats;
      if (got) begin
        img[acc_n / XF][(acc_n % XF) * DI +: DI] = s_data;
        bq.push_back(s_data);
        acc_n++;
      end
      if (mode == 0) begin
        if (!s_valid) gap--;
        else if (got && acc_n == 2 && !gapped) begin
          gap = 2; gapped = 1;
        end
      end
      tick();
      t++;
    end
    s_valid = 0;
    rd0_req = 0;
    @(negedge clk);
    chk("done_single_pulse", load_done, 0);
    chk("done_seen", t_done > 0, 1);
    chk("beats_accepted", acc_n, exp_beats);
    chk("din_valid_pulses", dv, exp_beats);
    chk("done_after_drain", t_done, lastdv + DRN + 1);
    chk("we_continuous", we_bad, 0);
    chk("s_ready_after_last", rdy_bad, 0);
    chk("no_gnt_in_load", gnt_bad, 0);
    chk("din_data", din_bad, 0);
    tick();
  endtask

  typedef struct {
    bit           r0;
    logic [A-1:0] a0;
    bit           r1;
    logic [A-1:0] a1;
    bit           g0;
    bit           g1;
  } vec_t;
  vec_t tbl[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    tbl[0] = '{1, 3'd0, 1, 3'd1, 1, 0};
    tbl[1] = '{1, 3'd0, 1, 3'd1, 0, 1};
    tbl[2] = '{1, 3'd0, 1, 3'd1, 1, 0};
    tbl[3] = '{1, 3'd0, 1, 3'd1, 0, 1};
    tbl[4] = '{0, 3'd1, 1, 3'd1, 0, 1};
    tbl[5] = '{1, 3'd1, 0, 3'd0, 1, 0};
    tbl[6] = '{0, 3'd1, 0, 3'd1, 0, 0};
    tbl[7] = '{1, 3'd1, 1, 3'd0, 0, 1};
    tbl[8] = '{1, 3'd1, 1, 3'd0, 1, 0};

    rd0_req = 1; rd1_req = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", uram_we, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", load_busy, 0);
    chk("rst_done", load_done, 0);
    chk("rst_gnt0", rd0_gnt, 0);
    chk("rst_gnt1", rd1_gnt, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_din_valid", uram_din_valid, 0);
    chk("rst_din", uram_din, 0);
    chk("rst_addr", uram_addr, 0);
    rst_n = 1;
    mon_en = 1;
    @(negedge clk);
    chk("idle_gnt0", rd0_gnt, 0);
    chk("idle_gnt1", rd1_gnt, 0);
    tick();
    rd0_req = 0; rd1_req = 0;

    // reset in the middle of a 3-row load
    load_start = 1; load_rows = 4'd3;
    tick();
    load_start = 0;
    s_valid = 1;
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      s_data = DI'($urandom);
      @(negedge clk);
      if (s_valid && s_ready) n++;
      tick();
    end
    chk("pre_reset_beats", n, 3);
    rd0_req = 1;
    rst_n = 0;
    #1;
    chk("midrst_we", uram_we, 0);
    chk("midrst_s_ready", s_ready, 0);
    chk("midrst_busy", load_busy, 0);
    chk("midrst_gnt0", rd0_gnt, 0);
    tick();
    chk("midrst_edge_we", uram_we, 0);
    chk("midrst_edge_s_ready", s_ready, 0);
    chk("midrst_edge_busy", load_busy, 0);
    chk("midrst_edge_gnt0", rd0_gnt, 0);
    rd0_req = 0; s_valid = 0;
    @(negedge clk);
    rst_n = 1;
    mlast = 1;
    tick();

    do_load(2, 0, 0, '0);
    for (int i = 0; i < 9; i++)
      rd_cyc(tbl[i].r0, tbl[i].a0, tbl[i].r1, tbl[i].a1,
             tbl[i].g0, tbl[i].g1);
    rd0_req = 0; rd1_req = 0;
    repeat (3) tick();

    // zero-row load
    load_start = 1; load_rows = '0;
    @(negedge clk);
    chk("zero_start_we", uram_we, 0);
    chk("zero_start_done", load_done, 0);
    tick();
    load_start = 0;
    @(negedge clk);
    chk("zero_done", load_done, 1);
    chk("zero_we", uram_we, 0);
    chk("zero_busy", load_busy, 0);
    tick();
    @(negedge clk);
    chk("zero_done_low", load_done, 0);
    chk("zero_we_after", uram_we, 0);
    tick();

    do_load(3, 1, 1, 3'd2);
    rand_reads(80, 3);
    repeat (4) tick();

    do_load(DEPTH + 5, 1, 0, '0);
    rand_reads(120, DEPTH);
    repeat (LAT + 3) tick();
    chk("rsp_queue_empty", rq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
